instr_fetch_unit: RTL and testbench

//   Fetch stage directly upstream of the instruction decoder. Holds the PC and issues word

---
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues word fetches to a 1-cycle synchronous imem and
// presents instr/pc/valid to the decoder through an output slot plus a 1-entry skid buffer.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ip_stall,
  input  logic        ip_branch_taken,
  input  logic [31:0] ip_branch_target,
  output logic        op_imem_req,
  output logic [31:0] op_imem_addr,
  input  logic [31:0] ip_imem_rdata,
  output logic [31:0] op_instr,
  output logic [31:0] op_instr_pc,
  output logic        op_instr_valid,
  output logic        op_misaligned
);

  // Decoder handshake: an instruction transfers in any cycle where op_instr_valid=1 and
  // ip_stall=0; while ip_stall=1 with valid=1, op_instr/op_instr_pc are held unchanged.

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        misaligned_q, misaligned_d;

  logic advance;
  logic redirect;
  logic req;

  assign advance  = !ip_stall || !out_valid_q;
  assign redirect = (state_q == RUN) && ip_branch_taken;
  // Never fetch when the skid could be needed but is occupied, so a response always has a home.
  assign req = (state_q == RUN) && !rst && !ip_branch_taken && !skid_valid_q
               && !(ip_stall && out_valid_q);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = req;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    misaligned_d  = misaligned_q;

    if (req) begin
      pc_d          = pc_q + PC_STEP;
      inflight_pc_d = pc_q;
    end

    if (redirect) begin
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
      if (ip_branch_target[1:0] != 2'b00) begin
        state_d      = HALT;
        misaligned_d = 1'b1;
      end else begin
        pc_d = ip_branch_target;
      end
    end else if (inflight_q) begin
      if (advance && !skid_valid_q) begin
        out_valid_d = 1'b1;
        out_instr_d = ip_imem_rdata;
        out_pc_d    = inflight_pc_q;
      end else if (advance) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_instr_d = ip_imem_rdata;
        skid_pc_d    = inflight_pc_q;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = ip_imem_rdata;
        skid_pc_d    = inflight_pc_q;
      end
    end else if (advance) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= 32'h0;
      skid_pc_q     <= 32'h0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'h0;
      out_pc_q      <= 32'h0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign op_imem_req    = req;
  assign op_imem_addr   = pc_q;
  assign op_instr       = out_instr_q;
  assign op_instr_pc    = out_pc_q;
  assign op_instr_valid = out_valid_q;
  assign op_misaligned  = misaligned_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle tables, a wrap-around check on a second
// instance, and a randomized stall/branch/reset run scored against a program-order model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        ivalid;
  logic        mis;

  logic        zero_b;
  logic [31:0] zero_w;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_ipc;
  logic        w_valid;
  logic        w_mis;

  int total;
  int bad;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .ip_stall(stall), .ip_branch_taken(br),
    .ip_branch_target(tgt), .op_imem_req(req), .op_imem_addr(addr),
    .ip_imem_rdata(rdata), .op_instr(instr), .op_instr_pc(ipc),
    .op_instr_valid(ivalid), .op_misaligned(mis)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .ip_stall(zero_b), .ip_branch_taken(zero_b),
    .ip_branch_target(zero_w), .op_imem_req(w_req), .op_imem_addr(w_addr),
    .ip_imem_rdata(w_rdata), .op_instr(w_instr), .op_instr_pc(w_ipc),
    .op_instr_valid(w_valid), .op_misaligned(w_mis)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instruction memory: word at byte address a holds a>>2; garbage when not requested
  always @(posedge clk) begin
    rdata   <= req   ? {2'b00, addr[31:2]}   : 32'hDEAD_BEEF;
    w_rdata <= w_req ? {2'b00, w_addr[31:2]} : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        r;
    logic        s;
    logic        b;
    logic [31:0] t;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
    logic        emis;
    logic        chk;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] exp_q[$];

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic ereq, input logic [31:0] eaddr, input logic ev,
                     input logic [31:0] epc, input logic emis, input logic chk);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.t = t;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc; v.emis = emis; v.chk = chk;
    tbl.push_back(v);
  endtask

  // driver: inputs change after the falling edge, outputs are sampled 1ns later
  task automatic apply(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; br = b; tgt = t;
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0d: actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic normal_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      if (k >= 2) add(0, 0, 0, 0, 1, 32'(4 * k), 1, 32'(4 * (k - 2)), 0, 1);
      else        add(0, 0, 0, 0, 1, 32'(4 * k), 0, 0, 0, 1);
    end
  endtask

  initial begin
    logic [31:0] wrap_addr[3];
    logic [31:0] nxt;
    logic        halted;
    int          halt_cnt;
    int          idle;
    int          delivered;
    logic        r, s, b;
    logic [31:0] t;

    total = 0; bad = 0;
    zero_b = 1'b0; zero_w = 32'h0;
    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0;

    // stream from reset, then stall 5..8 with skid capture and release
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    normal_cycles(5);
    for (int k = 5; k <= 8; k++) add(0, 1, 0, 0, 0, 0, 1, 32'h0C, 0, 1);
    add(0, 0, 0, 0, 0, 0,     1, 32'h0C, 0, 1);
    add(0, 0, 0, 0, 1, 32'h14, 1, 32'h10, 0, 1);
    add(0, 0, 0, 0, 1, 32'h18, 0, 0,      0, 1);
    add(0, 0, 0, 0, 1, 32'h1C, 1, 32'h14, 0, 1);
    add(0, 0, 0, 0, 1, 32'h20, 1, 32'h18, 0, 1);
    // redirect to 0x40 in cycle 6 while stalled
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    normal_cycles(6);
    add(0, 1, 1, 32'h40, 0, 0, 1, 32'h10, 0, 1);
    add(0, 0, 0, 0, 1, 32'h40, 0, 0,      0, 1);
    add(0, 0, 0, 0, 1, 32'h44, 0, 0,      0, 1);
    add(0, 0, 0, 0, 1, 32'h48, 1, 32'h40, 0, 1);
    add(0, 0, 0, 0, 1, 32'h4C, 1, 32'h44, 0, 1);
    // misaligned redirect: sticky halt, branches ignored, only reset clears
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    normal_cycles(3);
    add(0, 0, 1, 32'h42, 0, 0, 1, 32'h04, 0, 1);
    add(0, 0, 0, 0,      0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 32'h80, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0,      0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0,      0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0,      0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,      1, 0, 0, 0, 0, 1);
    // reset while stalled with the skid full
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    normal_cycles(5);
    add(0, 1, 0, 0, 0, 0, 1, 32'h0C, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 32'h0C, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h00, 0, 0,      0, 1);
    add(0, 0, 0, 0, 1, 32'h04, 0, 0,      0, 1);
    add(0, 0, 0, 0, 1, 32'h08, 1, 32'h00, 0, 1);
    add(0, 0, 0, 0, 1, 32'h0C, 1, 32'h04, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].t);
      check("req", i, {31'b0, req}, {31'b0, tbl[i].ereq});
      if (tbl[i].chk) begin
        if (tbl[i].ereq) check("addr", i, addr, tbl[i].eaddr);
        check("valid", i, {31'b0, ivalid}, {31'b0, tbl[i].ev});
        if (tbl[i].ev) begin
          check("pc", i, ipc, tbl[i].epc);
          check("instr", i, instr, {2'b00, tbl[i].epc[31:2]});
        end
        check("misaligned", i, {31'b0, mis}, {31'b0, tbl[i].emis});
      end
    end

    // PC wrap on the instance reset to 0xFFFF_FFF8
    wrap_addr[0] = 32'hFFFF_FFF8;
    wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000;
    apply(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      apply(0, 0, 0, 0);
      if (k < 3) begin
        check("wrap_req", k, {31'b0, w_req}, 32'h1);
        check("wrap_addr", k, w_addr, wrap_addr[k]);
      end
      if (k >= 2) begin
        check("wrap_pc", k, w_ipc, wrap_addr[k - 2]);
        check("wrap_instr", k, w_instr, {2'b00, wrap_addr[k - 2][31:2]});
      end
    end

    // randomized run against a program-order model
    apply(1, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(32'h0);
    halted = 1'b0; halt_cnt = 0; idle = 0; delivered = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 499) == 0) || (halted && halt_cnt > 20);
      s = ($urandom_range(0, 99) < 35);
      b = ($urandom_range(0, 99) < 4);
      t = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 29) == 0) t[1:0] = 2'($urandom_range(1, 3));
      apply(r, s, b, t);
      if (r) begin
        check("rnd_req_in_rst", i, {31'b0, req}, 32'h0);
        exp_q.delete();
        exp_q.push_back(32'h0);
        halted = 1'b0; halt_cnt = 0; idle = 0;
        continue;
      end
      check("rnd_misaligned", i, {31'b0, mis}, {31'b0, halted});
      if (halted) begin
        halt_cnt++;
        check("rnd_halt_req", i, {31'b0, req}, 32'h0);
        check("rnd_halt_valid", i, {31'b0, ivalid}, 32'h0);
      end else if (b) begin
        check("rnd_redirect_req", i, {31'b0, req}, 32'h0);
        idle = 0;
        if (t[1:0] != 2'b00) begin
          halted = 1'b1;
        end else begin
          exp_q.delete();
          exp_q.push_back(t);
        end
      end else if (ivalid && !s) begin
        nxt = exp_q.pop_front();
        check("rnd_pc", i, ipc, nxt);
        check("rnd_instr", i, instr, {2'b00, nxt[31:2]});
        exp_q.push_back(nxt + 32'd4);
        delivered++;
        idle = 0;
      end else if (!s) begin
        idle++;
        total++;
        if (idle > 6) begin
          bad++;
          $display("FAIL rnd_progress at %0d: actual=%0d idle cycles required<=6", i, idle);
          idle = 0;
        end
      end
    end
    total++;
    if (delivered < 500) begin
      bad++;
      $display("FAIL rnd_delivered: actual=%0d required>=500", delivered);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
